sampling_rate_ctrl: RTL and testbench

Parametrised sample-rate controller for the DDS function generator. It produces the `DDSEnable` sample strobe at one of `NUM_MODES` programmable divide ratios of `Fg_CLK`. Modes are selected by up/down buttons or by a direct load, and a mode change is applied only at a sample-period boundary, so no period is ever truncated. `DDSReady` is held low for a settle window after reset and after every mode change. The block sits between the button/interface logic and the DDS phase accumulator, whose advance it gates.

---
 rtl/sampling_rate_ctrl.sv | 128 ++++++++++++
 tb/tb_sampling_rate_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sampling_rate_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// sampling_rate_ctrl : DDS sample strobe at a selectable divide ratio,
// mode changes deferred to period boundaries, settle-window ready flag.
// Revision: 1.0
// ------------------------------------------------------------------
module sampling_rate_ctrl #(
  parameter int                         NUM_MODES  = 5,
  parameter int                         MODE_W     = 3,
  parameter int                         CNT_W      = 14,
  parameter logic [NUM_MODES*CNT_W-1:0] DIV_TABLE  = {14'd9999, 14'd999, 14'd99, 14'd9, 14'd0},
  parameter int                         RESET_MODE = 0,
  parameter int                         READY_HOLD = 80
) (
  input  logic              Fg_CLK,
  input  logic              Fg_RESET,
  input  logic              BtnUp,
  input  logic              BtnDown,
  input  logic              ModeLoad,
  input  logic [MODE_W-1:0] ModeIn,
  output logic              DDSEnable,
  output logic              DDSReady,
  output logic [MODE_W-1:0] DDSMode,
  output logic              ModePending
);

  localparam int                RDY_W      = $clog2(READY_HOLD + 1);
  localparam logic [MODE_W-1:0] RST_MODE   = MODE_W'(RESET_MODE);
  localparam logic [MODE_W-1:0] LAST_MODE  = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W:0]   MODE_LIMIT = (MODE_W + 1)'(NUM_MODES);
  localparam logic [RDY_W-1:0]  HOLD       = RDY_W'(READY_HOLD);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              en_q, en_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [MODE_W-1:0] target_q, target_d;
  logic              pend_q, pend_d;
  logic [RDY_W-1:0]  ready_cnt_q, ready_cnt_d;
  logic              ready_q, ready_d;
  logic              up_q, dn_q;

  logic [CNT_W-1:0]  div_tbl [2**MODE_W];
  logic [CNT_W-1:0]  div_cur;
  logic              term, apply;
  logic              up_edge, dn_edge, load_ok, req;
  logic [MODE_W-1:0] base, step_up, step_dn, req_mode;

  // Unused mode codes decode to DIV=0 so an out-of-range index stays bounded.
  for (genvar k = 0; k < 2**MODE_W; k++) begin : g_div
    if (k < NUM_MODES) begin : g_used
      assign div_tbl[k] = DIV_TABLE[k*CNT_W +: CNT_W];
    end else begin : g_unused
      assign div_tbl[k] = '0;
    end
  end

  always_comb begin
    div_cur = div_tbl[mode_q];
    term    = (cnt_q == div_cur);
    apply   = term & pend_q;
    up_edge = BtnUp & ~up_q;
    dn_edge = BtnDown & ~dn_q;
    load_ok = ModeLoad && ({1'b0, ModeIn} < MODE_LIMIT);

    // Steps chain off the pending target so repeated presses accumulate.
    base    = pend_q ? target_q : mode_q;
    step_up = (base == LAST_MODE) ? '0 : base + MODE_W'(1);
    step_dn = (base == '0) ? LAST_MODE : base - MODE_W'(1);

    req      = 1'b0;
    req_mode = base;
    if (load_ok) begin
      req      = 1'b1;
      req_mode = ModeIn;
    end else if (up_edge && !dn_edge) begin
      req      = 1'b1;
      req_mode = step_up;
    end else if (dn_edge && !up_edge) begin
      req      = 1'b1;
      req_mode = step_dn;
    end

    cnt_d    = term ? '0 : cnt_q + CNT_W'(1);
    en_d     = term;
    mode_d   = apply ? target_q : mode_q;
    target_d = req ? req_mode : target_q;
    pend_d   = req | (pend_q & ~apply);

    ready_cnt_d = ready_cnt_q;
    if (apply) begin
      ready_cnt_d = '0;
    end else if (ready_cnt_q != HOLD) begin
      ready_cnt_d = ready_cnt_q + RDY_W'(1);
    end
    ready_d = ~apply & (ready_cnt_q == HOLD);
  end

  always_ff @(posedge Fg_CLK) begin
    if (Fg_RESET) begin
      cnt_q       <= '0;
      en_q        <= 1'b0;
      mode_q      <= RST_MODE;
      target_q    <= RST_MODE;
      pend_q      <= 1'b0;
      ready_cnt_q <= '0;
      ready_q     <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      target_q    <= target_d;
      pend_q      <= pend_d;
      ready_cnt_q <= ready_cnt_d;
      ready_q     <= ready_d;
      up_q        <= BtnUp;
      dn_q        <= BtnDown;
    end
  end

  assign DDSEnable   = en_q;
  assign DDSReady    = ready_q;
  assign DDSMode     = mode_q;
  assign ModePending = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_sampling_rate_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_sampling_rate_ctrl : directed self-checking bench for sampling_rate_ctrl.
// Revision: 1.0
// ------------------------------------------------------------------
module tb_sampling_rate_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_up;
  logic       btn_dn;
  logic       mode_load;
  logic [2:0] mode_in;
  logic       dds_en;
  logic       dds_ready;
  logic [2:0] dds_mode;
  logic       mode_pend;

  int n_total;
  int n_pass;
  int n;

  sampling_rate_ctrl dut (
    .Fg_CLK      (clk),
    .Fg_RESET    (rst),
    .BtnUp       (btn_up),
    .BtnDown     (btn_dn),
    .ModeLoad    (mode_load),
    .ModeIn      (mode_in),
    .DDSEnable   (dds_en),
    .DDSReady    (dds_ready),
    .DDSMode     (dds_mode),
    .ModePending (mode_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One rising edge, then park on the falling edge to sample and drive.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic wait_en(input int max_ticks, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (dds_en !== 1'b1 && cnt < max_ticks);
    check("strobe_seen", 32'(dds_en), 32'd1);
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b1;
    btn_up    = 1'b0;
    btn_dn    = 1'b0;
    mode_load = 1'b0;
    mode_in   = 3'd0;
    @(negedge clk);
    ticks(3);
    check("rst_en",    32'(dds_en),    32'd0);
    check("rst_ready", 32'(dds_ready), 32'd0);
    check("rst_mode",  32'(dds_mode),  32'd0);
    check("rst_pend",  32'(mode_pend), 32'd0);

    // Mode 0, DIV=0: strobe every cycle from edge 0, ready after edge 80.
    rst = 1'b0;
    tick();
    check("m0_en_edge0", 32'(dds_en), 32'd1);
    for (int i = 1; i <= 79; i++) begin
      tick();
      if (i % 20 == 0) check("m0_en_cont", 32'(dds_en), 32'd1);
    end
    check("ready_edge79", 32'(dds_ready), 32'd0);
    tick();
    check("ready_edge80", 32'(dds_ready), 32'd1);

    // Single Up in mode 0.
    btn_up = 1'b1;
    tick();
    check("up_pend",     32'(mode_pend), 32'd1);
    check("up_mode_old", 32'(dds_mode),  32'd0);
    tick();
    btn_up = 1'b0;
    check("up_mode_new",  32'(dds_mode),  32'd1);
    check("up_pend_clr",  32'(mode_pend), 32'd0);
    check("up_ready_drop", 32'(dds_ready), 32'd0);
    check("up_close_strobe", 32'(dds_en), 32'd1);
    wait_en(20, n);
    check("m1_period", 32'(n), 32'd10);
    ticks(70);
    check("m1_ready_80", 32'(dds_ready), 32'd0);
    tick();
    check("m1_ready_81", 32'(dds_ready), 32'd1);

    // Move to mode 2, then Up at rCnt=10.
    wait_en(20, n);
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    wait_en(20, n);
    check("m2_mode", 32'(dds_mode), 32'd2);
    ticks(10);
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    check("m2_pend",      32'(mode_pend), 32'd1);
    check("m2_mode_hold", 32'(dds_mode),  32'd2);
    ticks(88);
    check("m2_pre_mode", 32'(dds_mode),  32'd2);
    check("m2_pre_pend", 32'(mode_pend), 32'd1);
    check("m2_pre_en",   32'(dds_en),    32'd0);
    tick();
    check("m3_mode",   32'(dds_mode),  32'd3);
    check("m3_strobe", 32'(dds_en),    32'd1);
    check("m3_pend",   32'(mode_pend), 32'd0);
    wait_en(1100, n);
    check("m3_period", 32'(n), 32'd1000);

    // Three Up presses in one mode-3 period: 3 -> 4 -> 0 -> 1.
    for (int i = 0; i < 3; i++) begin
      btn_up = 1'b1;
      tick();
      btn_up = 1'b0;
      tick();
    end
    check("x3_pend",  32'(mode_pend), 32'd1);
    check("x3_mode",  32'(dds_mode),  32'd3);
    check("x3_ready", 32'(dds_ready), 32'd1);
    wait_en(1100, n);
    check("x3_apply_mode",  32'(dds_mode),  32'd1);
    check("x3_apply_pend",  32'(mode_pend), 32'd0);
    check("x3_apply_ready", 32'(dds_ready), 32'd0);
    wait_en(20, n);
    check("x3_period", 32'(n), 32'd10);
    ticks(70);
    check("x3_ready_80", 32'(dds_ready), 32'd0);
    tick();
    check("x3_ready_81", 32'(dds_ready), 32'd1);

    // Up and Down edges together cancel.
    wait_en(20, n);
    btn_up = 1'b1;
    btn_dn = 1'b1;
    tick();
    check("updn_pend", 32'(mode_pend), 32'd0);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    tick();

    // Out-of-range load ignored.
    mode_load = 1'b1;
    mode_in   = 3'd6;
    tick();
    mode_load = 1'b0;
    check("ld6_pend", 32'(mode_pend), 32'd0);
    wait_en(20, n);
    check("ld6_mode", 32'(dds_mode), 32'd1);

    // Load mode 0, then Down from mode 0 wraps to 4.
    mode_load = 1'b1;
    mode_in   = 3'd0;
    tick();
    mode_load = 1'b0;
    check("ld0_pend", 32'(mode_pend), 32'd1);
    wait_en(20, n);
    check("ld0_mode", 32'(dds_mode), 32'd0);
    btn_dn = 1'b1;
    tick();
    check("dn_pend", 32'(mode_pend), 32'd1);
    check("dn_mode_old", 32'(dds_mode), 32'd0);
    tick();
    btn_dn = 1'b0;
    check("dn_wrap_mode", 32'(dds_mode), 32'd4);
    wait_en(10100, n);
    check("m4_period", 32'(n), 32'd10000);
    check("m4_ready",  32'(dds_ready), 32'd1);

    // Load 4 with Up on the same cycle: load wins, same-mode apply restarts settle.
    mode_load = 1'b1;
    mode_in   = 3'd4;
    btn_up    = 1'b1;
    tick();
    mode_load = 1'b0;
    btn_up    = 1'b0;
    check("ldup_pend", 32'(mode_pend), 32'd1);
    wait_en(10100, n);
    check("ldup_mode",  32'(dds_mode),  32'd4);
    check("ldup_ready", 32'(dds_ready), 32'd0);
    check("ldup_pend_clr", 32'(mode_pend), 32'd0);

    // Reset while a request is pending in mode 4.
    btn_up = 1'b1;
    tick();
    btn_up = 1'b0;
    check("rp_pend", 32'(mode_pend), 32'd1);
    rst = 1'b1;
    tick();
    check("rp_en",    32'(dds_en),    32'd0);
    check("rp_ready", 32'(dds_ready), 32'd0);
    check("rp_mode",  32'(dds_mode),  32'd0);
    check("rp_pend2", 32'(mode_pend), 32'd0);
    rst = 1'b0;
    tick();
    check("rp_post_en",   32'(dds_en),    32'd1);
    check("rp_post_mode", 32'(dds_mode),  32'd0);
    check("rp_post_pend", 32'(mode_pend), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
